// File: rtl/aes_issue_sched.sv
`default_nettype none
// aes_issue_sched: round-robin issue of plaintext/key pairs into a shared pipelined AES-128 core,
// with owner tags carried alongside the core latency for tagged responses.  Rev 1.0
module aes_issue_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 21
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic [NREQ*128-1:0]       i_req_state,
  input  logic [NREQ*128-1:0]       i_req_key,
  input  logic                      i_hold,
  output logic [127:0]              o_aes_state,
  output logic [127:0]              o_aes_key,
  input  logic [127:0]              i_aes_out,
  output logic [NREQ-1:0]           o_rsp_valid,
  output logic [127:0]              o_rsp_data,
  output logic [$clog2(LAT+2)-1:0]  o_inflight,
  output logic                      o_idle
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 2);
  // Stage 0 sits beside the core input register, so the last stage lines up with the core output.
  localparam int NS = LAT + 2;

  logic            r_run;
  logic [IW-1:0]   r_ptr;
  logic [127:0]    r_aes_state;
  logic [127:0]    r_aes_key;
  logic [NS-1:0]   r_tag_v;
  logic [IW-1:0]   r_tag_id [NS];
  logic [CW-1:0]   r_inflight;

  logic [NREQ-1:0] w_elig;
  logic            w_grant_vld;
  logic [IW-1:0]   w_grant_idx;
  logic [IW:0]     w_cand;
  logic [IW-1:0]   w_ptr_nxt;
  logic [127:0]    w_sel_state;
  logic [127:0]    w_sel_key;
  logic            w_retire;

  // r_run keeps grants off until the first edge seen out of reset.
  assign w_elig = i_req_valid & {NREQ{r_run & ~i_hold}};

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NREQ)) w_cand = w_cand - (IW+1)'(NREQ);
      if (!w_grant_vld && w_elig[w_cand[IW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_grant_vld) o_req_ready[w_grant_idx] = 1'b1;
  end

  assign w_ptr_nxt   = (w_grant_idx == IW'(NREQ - 1)) ? '0 : w_grant_idx + IW'(1);
  assign w_sel_state = i_req_state[128*w_grant_idx +: 128];
  assign w_sel_key   = i_req_key[128*w_grant_idx +: 128];

  // Counted retired once the tag enters the response stage, bounding the count at LAT+1.
  assign w_retire = r_tag_v[NS-2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run       <= 1'b0;
      r_ptr       <= '0;
      r_aes_state <= '0;
      r_aes_key   <= '0;
      r_tag_v     <= '0;
      r_inflight  <= '0;
    end else begin
      r_run   <= 1'b1;
      r_tag_v <= {r_tag_v[NS-2:0], w_grant_vld};
      if (w_grant_vld) begin
        r_aes_state <= w_sel_state;
        r_aes_key   <= w_sel_key;
        r_ptr       <= w_ptr_nxt;
      end
      if (w_grant_vld && !w_retire)
        r_inflight <= r_inflight + CW'(1);
      else if (!w_grant_vld && w_retire)
        r_inflight <= r_inflight - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NS; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_id[0] <= w_grant_idx;
      for (int s = 1; s < NS; s++) r_tag_id[s] <= r_tag_id[s-1];
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (r_tag_v[NS-1]) o_rsp_valid[r_tag_id[NS-1]] = 1'b1;
  end

  assign o_rsp_data  = i_aes_out;
  assign o_aes_state = r_aes_state;
  assign o_aes_key   = r_aes_key;
  assign o_inflight  = r_inflight;
  assign o_idle      = (r_inflight == '0);

endmodule
`default_nettype wire

// File: tb/tb_aes_issue_sched.sv
`default_nettype none
// tb_aes_issue_sched: AES core model plus an issue/response reference model compared every cycle,
// with directed scenarios pinned by FIPS-197 / SP800-38A literal ciphertexts.
module tb_aes_issue_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 21;
  localparam int CW   = $clog2(LAT + 2);

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] P3 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C3 = 128'hf5d3d58503b9699de785895a96fdbaaf;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_state = '0;
  logic [NREQ*128-1:0]  req_key = '0;
  logic                 hold = 1'b0;
  logic [127:0]         aes_state, aes_key, aes_out, rsp_data;
  logic [NREQ-1:0]      rsp_valid;
  logic [CW-1:0]        inflight;
  logic                 idle;

  always #5 clk = ~clk;

  aes_issue_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_state(req_state), .i_req_key(req_key), .i_hold(hold),
    .o_aes_state(aes_state), .o_aes_key(aes_key), .i_aes_out(aes_out),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_inflight(inflight), .o_idle(idle)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[rw+4*c] = t[rw+4*((c+rw)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      k[0] = k[0] ^ sbox_t[k[13]] ^ rc;
      k[1] = k[1] ^ sbox_t[k[14]];
      k[2] = k[2] ^ sbox_t[k[15]];
      k[3] = k[3] ^ sbox_t[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Core: output reflects the input sampled at edge t during the cycle after edge t+LAT.
  logic [127:0] core_pipe [LAT+1];
  always @(posedge clk) begin
    core_pipe[0] <= aes_enc(aes_state, aes_key);
    for (int i = 1; i <= LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign aes_out = core_pipe[LAT];

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic m_run;
  always @(posedge clk or negedge rst)
    if (!rst) m_run <= 1'b0;
    else      m_run <= 1'b1;

  // Reference: expected responses keyed by the cycle they must appear in.
  bit         exp_v    [64];
  int         exp_own  [64];
  logic [127:0] exp_data [64];
  int m_ptr = 0, pending = 0, m_xfer = -1, m_g, m_slot, m_inf, max_inf = 0;

  int           grant_q [$];
  int           gcyc_q  [$];
  logic [NREQ-1:0] rsp_own_q [$];
  logic [127:0] rsp_dat_q [$];
  int           rsp_cyc_q [$];

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_idle", idle, 1);
      for (int i = 0; i < 64; i++) exp_v[i] = 1'b0;
      pending = 0; m_ptr = 0; m_xfer = -1;
    end else begin
      m_slot = cyc % 64;
      chk("rsp_valid", rsp_valid, exp_v[m_slot] ? (1 << exp_own[m_slot]) : 0);
      if (exp_v[m_slot]) chk("rsp_data", rsp_data, exp_data[m_slot]);
      m_inf = pending - (exp_v[m_slot] ? 1 : 0);
      chk("inflight", inflight, m_inf);
      chk("idle", idle, (m_inf == 0) ? 1 : 0);
      if (exp_v[m_slot]) begin exp_v[m_slot] = 1'b0; pending--; end
      m_g = -1;
      if (m_run && !hold)
        for (int k = 0; k < NREQ; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
      chk("req_ready", req_ready, (m_g >= 0) ? (1 << m_g) : 0);
      if (m_g >= 0) begin
        m_slot = (cyc + LAT + 2) % 64;
        exp_v[m_slot]    = 1'b1;
        exp_own[m_slot]  = m_g;
        exp_data[m_slot] = aes_enc(req_state[128*m_g +: 128], req_key[128*m_g +: 128]);
        pending++;
        m_ptr = (m_g + 1) % NREQ;
      end
      m_xfer = m_g;
    end
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin grant_q.push_back(i); gcyc_q.push_back(cyc); end
    if (rsp_valid != 0) begin
      rsp_own_q.push_back(rsp_valid); rsp_dat_q.push_back(rsp_data); rsp_cyc_q.push_back(cyc);
    end
    if (int'(inflight) > max_inf) max_inf = int'(inflight);
  end

  // ---------------- stimulus ----------------
  logic [127:0] st [NREQ];
  logic [127:0] ky [NREQ];

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      req_state[128*i +: 128] = st[i];
      req_key[128*i +: 128]   = ky[i];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_q.delete(); gcyc_q.delete();
    rsp_own_q.delete(); rsp_dat_q.delete(); rsp_cyc_q.delete();
  endtask

  initial begin
    build_sbox();
    st[0] = P0; ky[0] = K0; st[1] = P1; ky[1] = K1;
    st[2] = P2; ky[2] = K1; st[3] = P3; ky[3] = K1;
    drive_bus();
    req_valid = 4'hf;
    #2 rst = 1'b0;
    tick(3);
    chk("reset_aes_state", aes_state, 0);
    chk("reset_aes_key", aes_key, 0);
    chk("reset_idle", idle, 1);
    clear_logs();
    max_inf = 0;
    rst = 1'b1;

    // All four continuously valid from reset.
    tick(40);
    chk("rr_grant0", grant_q[0], 0);
    chk("rr_grant1", grant_q[1], 1);
    chk("rr_grant2", grant_q[2], 2);
    chk("rr_grant3", grant_q[3], 3);
    chk("rr_grant4", grant_q[4], 0);
    chk("rr_own0", rsp_own_q[0], 4'b0001);
    chk("rr_own1", rsp_own_q[1], 4'b0010);
    chk("rr_own2", rsp_own_q[2], 4'b0100);
    chk("rr_own3", rsp_own_q[3], 4'b1000);
    chk("rr_ct0", rsp_dat_q[0], C0);
    chk("rr_ct1", rsp_dat_q[1], C1);
    chk("rr_ct2", rsp_dat_q[2], C2);
    chk("rr_ct3", rsp_dat_q[3], C3);
    chk("rr_back_to_back", rsp_cyc_q[3] - rsp_cyc_q[0], 3);
    chk("rr_latency", rsp_cyc_q[0] - (gcyc_q[0] + 1), LAT + 1);
    chk("rr_inflight_max", max_inf, LAT + 1);
    req_valid = '0;
    tick(30);

    // Single issue from requester 2.
    clear_logs();
    st[2] = P0; ky[2] = K0; drive_bus();
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(30);
    chk("single_count", rsp_own_q.size(), 1);
    chk("single_owner", rsp_own_q[0], 4'b0100);
    chk("single_ct", rsp_dat_q[0], C0);
    chk("single_latency", rsp_cyc_q[0] - (gcyc_q[0] + 1), LAT + 1);
    chk("single_idle", idle, 1);

    // Requesters 1 and 3 with the pointer at 2.
    req_valid = 4'b0010;
    tick(1);
    grant_q.delete();
    req_valid = 4'b1010;
    tick(3);
    req_valid = '0;
    chk("rr13_count", grant_q.size(), 3);
    chk("rr13_g0", grant_q[0], 3);
    chk("rr13_g1", grant_q[1], 1);
    chk("rr13_g2", grant_q[2], 3);
    tick(30);

    // hold while responses drain (pointer is back at 0).
    req_valid = 4'b0111;
    tick(3);
    req_valid = '0;
    tick(18);
    clear_logs();
    req_valid = 4'b0001; hold = 1'b1;
    tick(5);
    chk("hold_no_grant", grant_q.size(), 0);
    chk("hold_rsp_count", rsp_own_q.size(), 3);
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release_grant", req_ready, 4'b0001);
    chk("hold_drained", inflight, 0);
    @(posedge clk); #1;
    req_valid = '0;
    tick(30);

    // Reset with ten operations in flight.
    req_valid = 4'hf;
    tick(10);
    rst = 1'b0; req_valid = '0;
    clear_logs();
    tick(1);
    rst = 1'b1;
    tick(30);
    chk("rst_no_rsp", rsp_own_q.size(), 0);
    chk("rst_inflight0", inflight, 0);
    chk("rst_idle1", idle, 1);
    st[0] = P0; ky[0] = K0; drive_bus();
    req_valid = 4'b0101;
    tick(2);
    req_valid = '0;
    tick(30);
    chk("rst_ptr0_first", grant_q[0], 0);
    chk("rst_new_owner", rsp_own_q[0], 4'b0001);
    chk("rst_new_ct", rsp_dat_q[0], C0);
    chk("rst_new_latency", rsp_cyc_q[0] - (gcyc_q[0] + 1), LAT + 1);

    // Randomized traffic; each requester holds its request until transferred.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && m_xfer == i) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          st[i] = {$urandom, $urandom, $urandom, $urandom};
          ky[i] = {$urandom, $urandom, $urandom, $urandom};
        end else if (!req_valid[i] && $urandom_range(0, 9) < 4) begin
          req_valid[i] = 1'b1;
          st[i] = {$urandom, $urandom, $urandom, $urandom};
          ky[i] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      hold = ($urandom_range(0, 4) == 0);
      drive_bus();
      tick(1);
    end
    req_valid = '0; hold = 1'b0;
    tick(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
